inst_fetch_unit: RTL and testbench

IF stage of the 5-stage in-order RV64 pipeline. It sits directly upstream of the pipeline controller and ID.
- Owns the fetch PC and drives a single-outstanding request/ack instruction bus.
- Holds the fetched instruction for ID and produces the `fetched_ok` qualifier the controller uses to build its global advance signal.
- Consumes the controller's `dont_fetch`/`if_flush` and the jump/branch/trap redirect target.

---
 rtl/inst_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the fetch PC, drives a single-outstanding req/ack bus and presents one
// instruction (or bubble) to ID. Optional misaligned-target trap via FETCH_MISALIGN_CHK_EN.
module inst_fetch_unit #(
  parameter int unsigned            ADDR_W   = 64,
  parameter int unsigned            INST_W   = 32,
  parameter logic [ADDR_W-1:0]      PC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [INST_W-1:0]      NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_pipe_adv_i,
  input  logic              fetch_dont_fetch_i,
  input  logic              fetch_flush_i,
  input  logic              fetch_redirect_valid_i,
  input  logic [ADDR_W-1:0] fetch_redirect_pc_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              fetch_ack_i,
  input  logic [INST_W-1:0] fetch_rdata_i,
  output logic              fetch_fetched_ok_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic [INST_W-1:0] fetch_inst_o,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic              fetch_misalign_o,
`endif
  output logic              fetch_inst_nop_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_IDLE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [INST_W-1:0]   r_inst, w_inst_nxt;
  logic                r_drop, w_drop_nxt;
  logic                r_pend_valid, w_pend_valid_nxt;
  logic [ADDR_W-1:0]   r_pend_pc, w_pend_pc_nxt;
  logic [ADDR_W-1:0]   r_out_pc, w_out_pc_nxt;
  logic                w_go;
  logic [ADDR_W-1:0]   w_go_tgt;
`ifdef FETCH_MISALIGN_CHK_EN
  logic                r_misalign, w_misalign_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= PC_RESET;
      r_inst       <= NOP_INST;
      r_drop       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= PC_RESET;
      r_out_pc     <= PC_RESET;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_drop       <= w_drop_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_out_pc     <= w_out_pc_nxt;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign   <= w_misalign_nxt;
`endif
    end
  end

  // Next-state logic; w_go funnels every redirect through one place
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_drop_nxt       = r_drop;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_out_pc_nxt     = r_out_pc;
    w_go             = 1'b0;
    w_go_tgt         = fetch_redirect_pc_i;
`ifdef FETCH_MISALIGN_CHK_EN
    w_misalign_nxt   = r_misalign;
`endif

    case (r_state)
      S_REQ: begin
        if (fetch_ack_i) begin
          if (!r_drop && !fetch_redirect_valid_i) begin
            w_inst_nxt   = fetch_rdata_i;
            w_out_pc_nxt = r_pc;
            w_state_nxt  = S_HOLD;
          end else begin
            w_drop_nxt       = 1'b0;
            w_pend_valid_nxt = 1'b0;
            if (fetch_redirect_valid_i) begin
              w_go     = 1'b1;
              w_go_tgt = fetch_redirect_pc_i;
            end else if (r_pend_valid) begin
              w_go     = 1'b1;
              w_go_tgt = r_pend_pc;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end else if (fetch_redirect_valid_i) begin
          // Request cannot be withdrawn: remember the target and drop the reply
          w_pend_pc_nxt    = fetch_redirect_pc_i;
          w_pend_valid_nxt = 1'b1;
          w_drop_nxt       = 1'b1;
        end else if (fetch_flush_i) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_drop_nxt = r_drop;
        end
      end
      S_HOLD: begin
        if (fetch_pipe_adv_i) begin
          if (fetch_redirect_valid_i) begin
            w_go = 1'b1;
          end else if (fetch_flush_i) begin
            w_state_nxt = S_IDLE;
          end else if (fetch_dont_fetch_i) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_pc_nxt    = r_pc + ADDR_W'(4);
            w_state_nxt = S_REQ;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_IDLE: begin
        if (fetch_redirect_valid_i) begin
          w_go = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    if (w_go) begin
`ifdef FETCH_MISALIGN_CHK_EN
      if (w_go_tgt[1:0] != 2'b00) begin
        w_state_nxt    = S_IDLE;
        w_out_pc_nxt   = w_go_tgt;
        w_misalign_nxt = 1'b1;
      end else begin
        w_pc_nxt       = w_go_tgt;
        w_state_nxt    = S_REQ;
        w_misalign_nxt = 1'b0;
      end
`else
      w_pc_nxt    = w_go_tgt;
      w_state_nxt = S_REQ;
`endif
    end else begin
      w_go_tgt = w_go_tgt;
    end
  end

  assign fetch_req_o        = (r_state == S_REQ);
  assign fetch_addr_o       = r_pc;
  assign fetch_fetched_ok_o = (r_state != S_REQ);
  assign fetch_inst_o       = (r_state == S_HOLD) ? r_inst : NOP_INST;
  assign fetch_inst_nop_o   = (r_state != S_HOLD);
  assign fetch_pc_o         = r_out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_misalign_o   = r_misalign;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed literal checks, then randomized traffic against a
// behavioural model of the fetch stage. Honors FETCH_MISALIGN_CHK_EN.
module tb_inst_fetch_unit;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, adv, dont_fetch, flush, rv, ack;
  logic [63:0] rpc;
  logic [31:0] rdata;
  logic        req, ok, nop;
  logic [63:0] addr, pc;
  logic [31:0] inst;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        mis;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .fetch_pipe_adv_i(adv), .fetch_dont_fetch_i(dont_fetch), .fetch_flush_i(flush),
    .fetch_redirect_valid_i(rv), .fetch_redirect_pc_i(rpc),
    .fetch_req_o(req), .fetch_addr_o(addr), .fetch_ack_i(ack), .fetch_rdata_i(rdata),
    .fetch_fetched_ok_o(ok), .fetch_pc_o(pc), .fetch_inst_o(inst),
`ifdef FETCH_MISALIGN_CHK_EN
    .fetch_misalign_o(mis),
`endif
    .fetch_inst_nop_o(nop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: is a fetch in flight, is an instruction being shown, what is shown
  bit          m_fetching, m_showing, m_doomed, m_mis;
  logic [63:0] m_fetch_pc, m_show_pc;
  logic [31:0] m_show_inst;
  logic [63:0] m_later[$];

  task automatic model_reset();
    m_fetching = 1'b1; m_showing = 1'b0; m_doomed = 1'b0; m_mis = 1'b0;
    m_fetch_pc = PC_RESET; m_show_pc = PC_RESET; m_show_inst = NOP;
    m_later.delete();
  endtask

  task automatic model_go(input logic [63:0] t);
    m_showing = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    if (t[1:0] != 2'b00) begin
      m_fetching = 1'b0; m_show_pc = t; m_mis = 1'b1;
      return;
    end
    m_mis = 1'b0;
`endif
    m_fetching = 1'b1; m_fetch_pc = t;
  endtask

  task automatic model_step();
    logic [63:0] t;
    if (rst) begin
      model_reset();
    end else if (m_fetching) begin
      if (ack) begin
        if (!m_doomed && !rv) begin
          m_fetching = 1'b0; m_showing = 1'b1;
          m_show_inst = rdata; m_show_pc = m_fetch_pc;
        end else begin
          m_doomed = 1'b0;
          if (rv) begin
            m_later.delete(); model_go(rpc);
          end else if (m_later.size() > 0) begin
            t = m_later[$]; m_later.delete(); model_go(t);
          end else begin
            m_fetching = 1'b0; m_showing = 1'b0;
          end
        end
      end else if (rv) begin
        m_later.delete(); m_later.push_back(rpc); m_doomed = 1'b1;
      end else if (flush) begin
        m_doomed = 1'b1;
      end
    end else if (m_showing) begin
      if (adv) begin
        if (rv) model_go(rpc);
        else if (flush) m_showing = 1'b0;
        else if (!dont_fetch) begin
          m_showing = 1'b0; m_fetching = 1'b1; m_fetch_pc = m_fetch_pc + 64'd4;
        end
      end
    end else if (rv) begin
      model_go(rpc);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("req", {63'd0, req}, {63'd0, m_fetching});
    if (m_fetching) chk("addr", addr, m_fetch_pc);
    chk("fetched_ok", {63'd0, ok}, {63'd0, !m_fetching});
    chk("inst", {32'd0, inst}, {32'd0, m_showing ? m_show_inst : NOP});
    chk("nop", {63'd0, nop}, {63'd0, !m_showing});
    chk("pc", pc, m_show_pc);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign", {63'd0, mis}, {63'd0, m_mis});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int          slv_wait = -1;
  logic [63:0] t64;

  initial begin
    rst = 1'b1; adv = 1'b0; dont_fetch = 1'b0; flush = 1'b0; rv = 1'b0;
    rpc = 64'd0; ack = 1'b0; rdata = 32'd0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0; adv = 1'b1;
    chk("rst_req", {63'd0, req}, 64'd1);
    chk("rst_addr", addr, 64'h0000_0000_8000_0000);
    chk("rst_ok", {63'd0, ok}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'h13);
    chk("rst_pc", pc, 64'h0000_0000_8000_0000);

    // First fetch, ack after two waiting cycles
    tick(); tick();
    ack = 1'b1; rdata = 32'h0000_0513; tick(); ack = 1'b0;
    chk("d1_ok", {63'd0, ok}, 64'd1);
    chk("d1_inst", {32'd0, inst}, 64'h513);
    chk("d1_pc", pc, 64'h0000_0000_8000_0000);
    tick();
    chk("d1_next_addr", addr, 64'h0000_0000_8000_0004);

    // ID stall: instruction held, no request
    ack = 1'b1; rdata = 32'h0010_0093; tick(); ack = 1'b0;
    dont_fetch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d2_req", {63'd0, req}, 64'd0);
      chk("d2_inst", {32'd0, inst}, 64'h0010_0093);
    end
    dont_fetch = 1'b0; tick();
    chk("d2_addr", addr, 64'h0000_0000_8000_0008);

    // Redirect while REQ outstanding, two cycles before ack
    rv = 1'b1; rpc = 64'h0000_0000_8000_0200; tick(); rv = 1'b0;
    tick();
    ack = 1'b1; rdata = 32'hDEAD_BEEF; tick(); ack = 1'b0;
    chk("d4_ok", {63'd0, ok}, 64'd0);
    chk("d4_addr", addr, 64'h0000_0000_8000_0200);
    ack = 1'b1; rdata = 32'h0000_0513; tick(); ack = 1'b0;

    // Redirect from HOLD
    rv = 1'b1; rpc = 64'h0000_0000_8000_0100; tick(); rv = 1'b0;
    chk("d3_addr", addr, 64'h0000_0000_8000_0100);
    ack = 1'b1; tick(); ack = 1'b0;

    // Flush to IDLE, flush ignored there, redirect resumes
    flush = 1'b1; tick();
    chk("d5_ok", {63'd0, ok}, 64'd1);
    chk("d5_inst", {32'd0, inst}, 64'h13);
    chk("d5_nop", {63'd0, nop}, 64'd1);
    tick(); tick(); flush = 1'b0;
    chk("d5_req", {63'd0, req}, 64'd0);
    rv = 1'b1; rpc = 64'h0000_0000_8000_0004; tick(); rv = 1'b0;
    chk("d5_addr", addr, 64'h0000_0000_8000_0004);
    ack = 1'b1; tick(); ack = 1'b0;

    // PC wrap at the top of the address space
    rv = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFFC; tick(); rv = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    chk("wrap_addr", addr, 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;

`ifdef FETCH_MISALIGN_CHK_EN
    rv = 1'b1; rpc = 64'h0000_0000_8000_0102; tick(); rv = 1'b0;
    chk("mis_req", {63'd0, req}, 64'd0);
    chk("mis_flag", {63'd0, mis}, 64'd1);
    chk("mis_pc", pc, 64'h0000_0000_8000_0102);
    rv = 1'b1; rpc = 64'h0000_0000_8000_0300; tick(); rv = 1'b0;
    chk("mis_clear", {63'd0, mis}, 64'd0);
    chk("mis_addr", addr, 64'h0000_0000_8000_0300);
`endif

    // Randomized traffic with a bus slave answering after 0..3 cycles
    slv_wait = -1;
    for (int c = 0; c < 4000; c++) begin
      adv        = ($urandom_range(0, 9) < 7);
      dont_fetch = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      rv         = ($urandom_range(0, 11) == 0);
      t64 = 64'h0000_0000_8000_0000 + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 15) == 0) t64 = 64'hFFFF_FFFF_FFFF_FFF0 + {60'd0, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 7) == 0) t64[1:0] = 2'($urandom_range(1, 3));
      rpc   = t64;
      rdata = $urandom;
      rst   = ($urandom_range(0, 499) == 0);
      ack   = 1'b0;
      if (rst) begin
        slv_wait = -1;
      end else if (req) begin
        if (slv_wait < 0) slv_wait = $urandom_range(0, 3);
        if (slv_wait == 0) begin
          ack = 1'b1; slv_wait = -1;
        end else begin
          slv_wait--;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
